// File: rtl/controle_redimensionamento.sv
// Sequencer for the image-scaling engines: blanks the framebuffer, releases one
// engine, forwards its memory ports to the shared ROM/RAM and watches for done.
module controle_redimensionamento #(
    parameter int N_ENG    = 4,
    parameter int RAM_SIZE = 307200,
    parameter int TIMEOUT  = 1048575
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op_sel,
    input  logic                 zoom_in,
    input  logic [N_ENG-1:0]     eng_done,
    input  logic [N_ENG*15-1:0]  eng_rom_addr,
    input  logic [N_ENG-1:0]     eng_ram_wren,
    input  logic [N_ENG*19-1:0]  eng_ram_addr,
    input  logic [N_ENG*8-1:0]   eng_ram_data,
    output logic [N_ENG-1:0]     eng_reset,
    output logic                 zoom_out,
    output logic [14:0]          rom_addr_out,
    output logic                 ram_wren_out,
    output logic [18:0]          ram_addr_out,
    output logic [7:0]           ram_data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           active_op
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, LAUNCH, RUN, DONE_ST, ERROR_ST
    } state_t;

    localparam logic [18:0]      CNT_LAST = 19'(RAM_SIZE - 1);
    localparam logic [19:0]      WD_LAST  = 20'(TIMEOUT - 1);
    localparam logic [N_ENG-1:0] ONE      = N_ENG'(1);

    state_t      state;
    logic [18:0] cnt;
    logic [19:0] wd;
    logic        op_ok;

    logic [N_ENG-1:0][14:0] rom_a;
    logic [N_ENG-1:0][18:0] ram_a;
    logic [N_ENG-1:0][7:0]  ram_d;

    for (genvar i = 0; i < N_ENG; i++) begin : g_unpack
        assign rom_a[i] = eng_rom_addr[i*15 +: 15];
        assign ram_a[i] = eng_ram_addr[i*19 +: 19];
        assign ram_d[i] = eng_ram_data[i*8 +: 8];
    end

    assign op_ok = (int'(op_sel) < N_ENG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            eng_reset    <= '1;
            zoom_out     <= 1'b0;
            rom_addr_out <= '0;
            ram_wren_out <= 1'b0;
            ram_addr_out <= '0;
            ram_data_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            active_op    <= '0;
        end else begin
            case (state)
                IDLE, DONE_ST, ERROR_ST: begin
                    ram_wren_out <= 1'b0;
                    if (start) begin
                        done <= 1'b0;
                        if (op_ok) begin
                            state     <= CLEAR;
                            cnt       <= '0;
                            active_op <= op_sel;
                            zoom_out  <= zoom_in;
                            busy      <= 1'b1;
                            error     <= 1'b0;
                        end else begin
                            state <= ERROR_ST;
                            error <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ram_wren_out <= 1'b1;
                    ram_addr_out <= cnt;
                    ram_data_out <= 8'h00;
                    // counter parks on the last address instead of wrapping
                    if (cnt == CNT_LAST) state <= LAUNCH;
                    else                 cnt   <= cnt + 19'd1;
                end
                LAUNCH: begin
                    ram_wren_out <= 1'b0;
                    eng_reset    <= ~(ONE << active_op);
                    wd           <= '0;
                    state        <= RUN;
                end
                RUN: begin
                    // forward even on the done cycle so the engine's last write lands
                    rom_addr_out <= rom_a[active_op];
                    ram_wren_out <= eng_ram_wren[active_op];
                    ram_addr_out <= ram_a[active_op];
                    ram_data_out <= ram_d[active_op];
                    wd           <= wd + 20'd1;
                    if (eng_done[active_op]) begin
                        state     <= DONE_ST;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        eng_reset <= '1;
                    end else if (wd == WD_LAST) begin
                        state     <= ERROR_ST;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        eng_reset <= '1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_controle_redimensionamento.sv
// Bench for controle_redimensionamento: elapsed-time reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_controle_redimensionamento;
    localparam int N = 4, RAM = 8, TMO = 16;

    logic clk = 1'b0;
    logic reset, start, zoom_in;
    logic [1:0] op_sel;
    logic [N-1:0] eng_done, eng_ram_wren;
    logic [N*15-1:0] eng_rom_addr;
    logic [N*19-1:0] eng_ram_addr;
    logic [N*8-1:0] eng_ram_data;
    logic [N-1:0] eng_reset;
    logic zoom_out, ram_wren_out, busy, done, error;
    logic [14:0] rom_addr_out;
    logic [18:0] ram_addr_out;
    logic [7:0] ram_data_out;
    logic [1:0] active_op;

    controle_redimensionamento #(.N_ENG(N), .RAM_SIZE(RAM), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .zoom_in(zoom_in),
        .eng_done(eng_done), .eng_rom_addr(eng_rom_addr), .eng_ram_wren(eng_ram_wren),
        .eng_ram_addr(eng_ram_addr), .eng_ram_data(eng_ram_data), .eng_reset(eng_reset),
        .zoom_out(zoom_out), .rom_addr_out(rom_addr_out), .ram_wren_out(ram_wren_out),
        .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out), .busy(busy),
        .done(done), .error(error), .active_op(active_op)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is measured in edges since the accepted start.
    bit m_sess = 1'b0;
    int m_t = 0;
    logic [N-1:0] e_engrst;
    logic [14:0] e_rom;
    logic e_wren, e_zoom, e_busy, e_done, e_err;
    logic [18:0] e_waddr;
    logic [7:0] e_wdata;
    logic [1:0] e_act;

    always @(posedge clk) begin
        if (reset) begin
            m_sess = 1'b0; e_engrst = '1; e_rom = '0; e_wren = 1'b0; e_waddr = '0;
            e_wdata = '0; e_zoom = 1'b0; e_act = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
        end else if (!m_sess) begin
            e_wren = 1'b0;
            if (start) begin
                if (int'(op_sel) < N) begin
                    m_sess = 1'b1; m_t = 0; e_act = op_sel; e_zoom = zoom_in;
                    e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0;
                end else begin
                    e_err = 1'b1; e_done = 1'b0;
                end
            end
        end else begin
            m_t++;
            if (m_t <= RAM) begin
                e_wren = 1'b1; e_waddr = 19'(m_t - 1); e_wdata = 8'h00;
            end else if (m_t == RAM + 1) begin
                e_wren = 1'b0; e_engrst = '1; e_engrst[e_act] = 1'b0;
            end else begin
                e_rom   = eng_rom_addr[e_act*15 +: 15];
                e_wren  = eng_ram_wren[e_act];
                e_waddr = eng_ram_addr[e_act*19 +: 19];
                e_wdata = eng_ram_data[e_act*8 +: 8];
                if (eng_done[e_act]) begin
                    m_sess = 1'b0; e_done = 1'b1; e_busy = 1'b0; e_engrst = '1;
                end else if (m_t - RAM - 1 == TMO) begin
                    m_sess = 1'b0; e_err = 1'b1; e_busy = 1'b0; e_engrst = '1;
                end
            end
        end
    end

    // Per-cycle comparison and write log.
    logic [18:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [N-1:0] rel_seen = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("eng_reset", 32'(eng_reset), 32'(e_engrst));
            chk("zoom_out", 32'(zoom_out), 32'(e_zoom));
            chk("rom_addr_out", 32'(rom_addr_out), 32'(e_rom));
            chk("ram_wren_out", 32'(ram_wren_out), 32'(e_wren));
            chk("ram_addr_out", 32'(ram_addr_out), 32'(e_waddr));
            chk("ram_data_out", 32'(ram_data_out), 32'(e_wdata));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("error", 32'(error), 32'(e_err));
            chk("active_op", 32'(active_op), 32'(e_act));
            rel_seen = rel_seen | ~eng_reset;
            if (ram_wren_out === 1'b1) begin
                wa_q.push_back(ram_addr_out);
                wd_q.push_back(ram_data_out);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int idx);
        int n = 0;
        while (eng_reset[idx] !== 1'b0 && n < 60) begin
            step();
            n++;
        end
        chk("engine_release", 32'(eng_reset[idx]), 32'd0);
    endtask

    task automatic pulse_start(input logic [1:0] op, input logic z);
        op_sel = op; zoom_in = z; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n, n0;
        reset = 1'b1; start = 1'b0; op_sel = '0; zoom_in = 1'b0; eng_done = '0;
        eng_ram_wren = 4'b1101;
        for (int i = 0; i < N; i++) begin
            eng_rom_addr[i*15 +: 15] = 15'(32'h7000 + i);
            eng_ram_addr[i*19 +: 19] = 19'(32'h40000 + i * 16);
            eng_ram_data[i*8 +: 8]   = 8'(32'hF0 + i);
        end
        step(); chk_en = 1'b1; step(); step();
        chk("rst_eng_reset", 32'(eng_reset), 32'hF);
        chk("rst_outputs", {busy, done, error, ram_wren_out, zoom_out, active_op}, 32'd0);
        reset = 1'b0;
        step();

        // normal run on engine 1 with zoom
        pulse_start(2'd1, 1'b1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_active_op", 32'(active_op), 32'd1);
        step();
        chk("first_clear_addr", {12'd0, ram_wren_out, ram_addr_out}, {12'd0, 1'b1, 19'd0});
        step(); step();
        pulse_start(2'd2, 1'b0);
        wait_rel(1);
        chk("run_eng_reset", 32'(eng_reset), 32'b1101);
        chk("clear_writes", 32'(wa_q.size()), 32'd8);
        for (int i = 0; i < RAM && i < wa_q.size(); i++)
            chk("clear_word", {wd_q[i], 5'd0, wa_q[i]}, 32'(i));
        for (int i = 0; i < 4; i++) begin
            eng_rom_addr[15 +: 15] = 15'(32'h200 + i);
            eng_ram_wren[1] = 1'b1;
            eng_ram_addr[19 +: 19] = 19'(32'h100 + i);
            eng_ram_data[8 +: 8] = 8'(32'hA0 + i);
            start = (i == 1); op_sel = 2'd2;
            eng_done[1] = (i == 3);
            step();
            chk("fwd_addr", 32'(ram_addr_out), 32'h100 + i);
        end
        start = 1'b0; eng_done[1] = 1'b0; eng_ram_wren[1] = 1'b0;
        chk("done_flag", {done, busy, error}, 32'b100);
        chk("done_eng_reset", 32'(eng_reset), 32'hF);
        chk("last_write", {ram_wren_out, 4'd0, rom_addr_out, ram_data_out}, {1'b1, 4'd0, 15'h203, 8'hA3});
        step();
        chk("done_wren_off", {done, ram_wren_out}, 32'b10);
        chk("total_writes", 32'(wa_q.size()), 32'd12);
        for (int i = 8; i < 12 && i < wa_q.size(); i++)
            chk("engine_word", {5'd0, wa_q[i], wd_q[i]}, {5'd0, 19'(32'h100 + i - 8), 8'(32'hA0 + i - 8)});

        // restart from DONE on engine 3
        pulse_start(2'd3, 1'b0);
        chk("restart_state", {done, busy, 1'b0, zoom_out, active_op}, 32'b010011);
        wait_rel(3);
        chk("op3_eng_reset", 32'(eng_reset), 32'b0111);
        step(); step();
        eng_done[3] = 1'b1; step(); eng_done[3] = 1'b0;
        chk("op3_done", 32'(done), 32'd1);
        chk("released_engines", 32'(rel_seen), 32'b1010);

        // watchdog on engine 0, which never finishes
        pulse_start(2'd0, 1'b0);
        wait_rel(0);
        n = 0;
        while (error !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("watchdog_cycles", 32'(n), 32'd16);
        chk("wd_flags", {busy, done, error, eng_reset}, {3'b001, 4'hF});
        step();
        chk("wd_wren_off", {error, ram_wren_out}, 32'b10);

        // reset in the middle of a run on engine 2
        pulse_start(2'd2, 1'b1);
        chk("error_cleared", 32'(error), 32'd0);
        wait_rel(2);
        step(); step();
        chk("pre_reset_write", 32'(ram_wren_out), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_reset", {busy, ram_wren_out, eng_reset}, {2'b00, 4'hF});
        n0 = wa_q.size();
        step(); step(); step();
        chk("no_write_after_reset", 32'(wa_q.size()), 32'(n0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/controle_redimensionamento.md
# controle_redimensionamento

Top-level sequencer for the image-scaling engines (nearest-neighbour zoom and its sibling algorithms). It accepts a start command with an algorithm select, blanks the 640x480 framebuffer, then releases exactly one engine from reset. While that engine runs, the block forwards the engine's ROM and RAM ports to the shared memories and waits for its `done`, with a watchdog to catch a hung engine. It sits between the board I/O (buttons and switches) and the engine instances, and it is the only writer of the framebuffer RAM port.

## Interface
Parameters:
- `N_ENG`, 4: number of attached scaling engines; engine index = `op_sel`.
- `RAM_SIZE`, 307200: framebuffer words (640*480).
- `TIMEOUT`, 1048575: maximum RUN cycles before error.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle command pulse (pre-debounced).
- `op_sel` in 2: engine index to run.
- `zoom_in` in 1: zoom request, latched at start.
- `eng_done` in N_ENG: per-engine done.
- `eng_rom_addr` in N_ENG*15: per-engine ROM address, engine i at bits [15i+14:15i].
- `eng_ram_wren` in N_ENG: per-engine RAM write enable.
- `eng_ram_addr` in N_ENG*19: per-engine RAM address.
- `eng_ram_data` in N_ENG*8: per-engine RAM data.
- `eng_reset` out N_ENG: bit i high holds engine i in reset.
- `zoom_out` out 1: latched zoom, fanned out to all engines.
- `rom_addr_out` out 15: shared ROM address.
- `ram_wren_out` out 1: shared RAM write enable.
- `ram_addr_out` out 19: shared RAM address.
- `ram_data_out` out 8: shared RAM data.
- `busy` out 1: high in CLEAR, LAUNCH and RUN.
- `done` out 1: high in DONE.
- `error` out 1: high in ERROR.
- `active_op` out 2: latched `op_sel`.

## Operation
- States: IDLE, CLEAR, LAUNCH, RUN, DONE, ERROR.
- IDLE, DONE, ERROR:
  - `start`=1 with `op_sel`<N_ENG: latch `op_sel` into `active_op` and `zoom_in` into `zoom_out`; clear the address counter; go to CLEAR.
  - `start`=1 with `op_sel`>=N_ENG: go to ERROR.
  - `start` is ignored in every other state.
- CLEAR:
  - Each cycle write 0x00 to address `cnt`, `cnt` running 0..RAM_SIZE-1 (RAM_SIZE writes, no gaps).
  - After the write at RAM_SIZE-1, go to LAUNCH.
- LAUNCH:
  - One cycle; `ram_wren_out`=0.
  - Deassert `eng_reset[active_op]`; other bits stay 1.
  - Clear the watchdog; go to RUN.
- RUN:
  - Each cycle, register the selected engine's rom_addr, ram_wren, ram_addr and ram_data onto the shared outputs.
  - Non-selected engines' inputs are never forwarded.
  - Watchdog increments each cycle.
  - If `eng_done[active_op]`=1: go to DONE. That cycle's engine port values are still forwarded, so its final write is not lost.
  - Else if watchdog == TIMEOUT-1: go to ERROR.
  - Done takes priority over timeout when both occur in the same cycle.
- Entering DONE or ERROR: `eng_reset` all 1; `ram_wren_out` forced 0 from the next cycle on.
- The address counter is 19 bits and never wraps: it stops at RAM_SIZE-1. The watchdog is 20 bits.

## Timing
- Reset values (every output, and registers as listed):
  - State IDLE.
  - `eng_reset` all 1.
  - `ram_wren_out`, `ram_addr_out`, `ram_data_out`, `rom_addr_out`, `zoom_out`, `active_op` = 0.
  - `busy`, `done`, `error` = 0.
- Reset mid-operation: takes effect on the next edge; returns to IDLE with the reset values above. The partially cleared or partially written frame is abandoned, with no further writes.
- All outputs are registered; no combinational input-to-output path.
- Start latency: `start` at edge k puts the first clear write (addr 0) on the outputs after edge k+1.
- CLEAR occupies exactly RAM_SIZE cycles; LAUNCH occupies 1 cycle.
- Engine release: `eng_reset[active_op]` goes low at the LAUNCH->RUN edge.
- Forwarding latency in RUN: exactly 1 cycle (engine port at edge n appears on the shared port after edge n+1).
- `done` is asserted the cycle after `eng_done` is sampled high.
- Status flags:
  - `busy`, `done` and `error` are mutually exclusive.
  - `done` and `error` stay high until the next accepted `start` or `reset`.

## Test plan
- Reset: hold `reset` for 3 cycles -> `eng_reset`=4'b1111; all other outputs 0; state IDLE.
- Normal run, `op_sel`=1, `zoom_in`=1, mock engine 1 writes 4 words then raises done:
  - Exactly 307200 writes of 0x00 at addresses 0..307199, then 1 LAUNCH cycle, then `eng_reset`=4'b1101.
  - The 4 engine writes appear 1 cycle delayed, addr/data intact.
  - `done`=1 the cycle after `eng_done[1]`; `eng_reset` returns to 4'b1111.
- Start ignored: pulse `start` with `op_sel`=2 during CLEAR and during RUN -> `active_op` stays 1; no restart; engine 2 stays in reset.
- Watchdog (`TIMEOUT`=16, `RAM_SIZE`=8), engine never done -> `error`=1 after 16 RUN cycles; `ram_wren_out`=0; all `eng_reset`=1.
- Mid-RUN reset: assert `reset` while the engine is writing -> `ram_wren_out`=0 and IDLE on the next edge; no write follows.
- Restart from DONE with `op_sel`=3 -> new CLEAR pass; engine 3 released; engines 0-2 never released.
